// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: 8 blocks x 16 bytes between CPU fetch and block memory.
// Latency: a hit returns the word combinationally; a miss stalls for 3 cycles plus the memory wait cycles.
// Backpressure: o_busywait stalls the CPU during a miss; i_mem_busywait holds the refill in MEM_FETCH.
module icache_direct_mapped #(
   parameter int ADDR_WIDTH  = 10,
   parameter int INDEX_BITS  = 3,
   parameter int OFFSET_BITS = 4
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [31:0]                       i_pc,
   output logic [31:0]                       o_instruction,
   output logic                              o_busywait,
   output logic                              o_mem_read,
   output logic [ADDR_WIDTH-OFFSET_BITS-1:0] o_mem_address,
   input  logic [127:0]                      i_mem_readdata,
   input  logic                              i_mem_busywait
);

   localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int NUM_BLOCKS = 1 << INDEX_BITS;
   localparam int BLOCK_BITS = 128;
   localparam int WSEL_BITS  = OFFSET_BITS - 2;

   // Block address of an outstanding refill; its packed layout is exactly the memory address {tag,index}.
   typedef struct packed {
      logic [TAG_BITS-1:0]   tag;
      logic [INDEX_BITS-1:0] index;
   } blk_addr_t;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MEM_FETCH = 2'd1,
      S_UPDATE    = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   blk_addr_t               r_fetch;
   logic [BLOCK_BITS-1:0]   r_refill;
   logic [NUM_BLOCKS-1:0]   r_valid;
   logic [TAG_BITS-1:0]     r_tag  [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0]   r_data [NUM_BLOCKS];

   logic [INDEX_BITS-1:0]   w_index;
   logic [TAG_BITS-1:0]     w_tag;
   logic [WSEL_BITS-1:0]    w_word;
   logic [WSEL_BITS+4:0]    w_word_lsb;
   logic [BLOCK_BITS-1:0]   w_line;
   logic                    w_hit;
   logic                    w_busy_fsm;
   logic                    w_mem_read;
   logic                    w_start_fetch;
   logic                    w_mem_done;
   logic                    w_install;
   logic                    w_unused_pc;

   // PC decode: bits above the instruction space and the byte-in-word bits carry no information here.
   assign w_index     = i_pc[OFFSET_BITS +: INDEX_BITS];
   assign w_tag       = i_pc[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
   assign w_word      = i_pc[2 +: WSEL_BITS];
   assign w_unused_pc = ^{i_pc[31:ADDR_WIDTH], i_pc[1:0]};

   // Lookup and word select are purely combinational so a hit costs no cycle.
   assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_line        = r_data[w_index];
   assign w_word_lsb    = {w_word, 5'd0};
   assign o_instruction = w_line[w_word_lsb +: 32];

   // Stall is forced low during reset so the CPU is not held by a stale miss indication.
   assign o_busywait    = !i_reset && w_busy_fsm;
   assign o_mem_read    = w_mem_read;
   assign o_mem_address = r_fetch;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and output decode for the miss sequence IDLE -> MEM_FETCH -> UPDATE -> IDLE.
   always_comb begin
      w_next_state  = r_state;
      w_busy_fsm    = 1'b1;
      w_mem_read    = 1'b0;
      w_start_fetch = 1'b0;
      w_mem_done    = 1'b0;
      w_install     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy_fsm = !w_hit;
            if (!w_hit) begin
               w_start_fetch = 1'b1;
               w_next_state  = S_MEM_FETCH;
            end
         end
         S_MEM_FETCH: begin
            w_mem_read = 1'b1;
            if (!i_mem_busywait) begin
               w_mem_done   = 1'b1;
               w_next_state = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_install    = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Fetch register: remembers which block is being refilled, independent of later PC changes.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch <= '0;
      end else if (w_start_fetch) begin
         r_fetch <= blk_addr_t'{tag: w_tag, index: w_index};
      end
   end

   // Refill buffer: captures the block in the cycle memory reports it ready.
   always_ff @(posedge i_clk) begin
      if (w_mem_done) begin
         r_refill <= i_mem_readdata;
      end
   end

   // Valid bits: cleared by reset, set only when a refill is installed.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= '0;
      end else if (w_install) begin
         r_valid[r_fetch.index] <= 1'b1;
      end
   end

   // Tag and data arrays: written only on install; a reset in UPDATE abandons the refill.
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_install) begin
         r_tag[r_fetch.index]  <= r_fetch.tag;
         r_data[r_fetch.index] <= r_refill;
      end
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Testbench for icache_direct_mapped: directed scenarios plus a randomized fetch stream.
// Latency: expected stall counts derive from hit/miss and the modelled memory wait.
// Backpressure: a behavioural memory holds its busy flag for a programmable number of cycles.
module tb_icache_direct_mapped;

   logic         clk;
   logic         reset;
   logic [31:0]  pc;
   logic [31:0]  instr;
   logic         busy;
   logic         mem_read;
   logic [5:0]   mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_busy;

   logic [127:0] mem_blk [64];
   int           mem_lat;
   int           lat_cnt;

   int           n_vec;
   int           n_err;

   bit           m_valid [8];
   logic [2:0]   m_tag   [8];

   icache_direct_mapped dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_pc           (pc),
      .o_instruction  (instr),
      .o_busywait     (busy),
      .o_mem_read     (mem_read),
      .o_mem_address  (mem_addr),
      .i_mem_readdata (mem_rdata),
      .i_mem_busywait (mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: busy for mem_lat cycles of an active read, garbage data while busy.
   always @(posedge clk) begin
      if (mem_read) lat_cnt <= lat_cnt + 1;
      else          lat_cnt <= 0;
   end
   assign mem_busy  = mem_read && (lat_cnt < mem_lat);
   assign mem_rdata = mem_busy ? {4{32'hDEADBEEF}} : mem_blk[mem_addr];

   // Reference model: the word the CPU should see at byte address a.
   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [127:0] blk;
      int           w;
      blk = mem_blk[a[9:4]];
      w   = int'(a[3:2]);
      return blk[w*32 +: 32];
   endfunction

   function automatic bit ref_hit(input logic [31:0] a);
      return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
   endfunction

   task automatic ref_install(input logic [31:0] a);
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]]   = a[9:7];
   endtask

   task automatic ref_clear();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
   endtask

   // Presents a fetch and measures it: stall cycles, read cycles, wrong-address cycles, final word.
   task automatic do_fetch(input logic [31:0] a, output int nbusy, output int nrd,
                           output int nbad, output logic [31:0] ins, output bit tmo);
      nbusy = 0; nrd = 0; nbad = 0; ins = '0; tmo = 1'b1;
      @(negedge clk);
      pc = a;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (busy === 1'b0) begin
            ins = instr;
            tmo = 1'b0;
            break;
         end
         nbusy++;
         if (mem_read === 1'b1) begin
            nrd++;
            if (mem_addr !== a[9:4]) nbad++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pc    = 32'h0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      @(posedge clk);
      @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy2 got %b want 0", busy); end
      n_vec++;
      if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
      n_vec++;
      if (mem_addr !== 6'h00) begin n_err++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
      reset = 1'b0;
      ref_clear();
   endtask

   task automatic test_cold_miss();
      int nb, nr, nbad; logic [31:0] ins; bit tmo;
      mem_lat = 5;
      do_fetch(32'h000, nb, nr, nbad, ins, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL cold_timeout got stuck want done"); end
      n_vec++; if (nb != 8) begin n_err++; $display("FAIL cold_busy got %0d want 8", nb); end
      n_vec++; if (nr != 6) begin n_err++; $display("FAIL cold_mem_read got %0d want 6", nr); end
      n_vec++; if (nbad != 0) begin n_err++; $display("FAIL cold_mem_addr got %0d bad cycles want 0", nbad); end
      n_vec++; if (ins !== 32'h09000001) begin n_err++; $display("FAIL cold_word got %h want 09000001", ins); end
      ref_install(32'h000);
   endtask

   task automatic test_same_block_hits();
      int nb, nr, nbad; logic [31:0] ins; bit tmo;
      for (int k = 1; k < 4; k++) begin
         do_fetch(32'(k*4), nb, nr, nbad, ins, tmo);
         n_vec++; if (nb != 0 || tmo) begin n_err++; $display("FAIL hit_busy pc=%h got %0d want 0", k*4, nb); end
         n_vec++; if (nr != 0) begin n_err++; $display("FAIL hit_mem_read pc=%h got %0d want 0", k*4, nr); end
         n_vec++; if (ins !== ref_word(32'(k*4))) begin n_err++; $display("FAIL hit_word pc=%h got %h want %h", k*4, ins, ref_word(32'(k*4))); end
      end
   endtask

   task automatic test_next_block();
      int nb, nr, nbad; logic [31:0] ins; bit tmo;
      do_fetch(32'h010, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 8 || tmo) begin n_err++; $display("FAIL blk1_busy got %0d want 8", nb); end
      n_vec++; if (nr != 6 || nbad != 0) begin n_err++; $display("FAIL blk1_read got %0d cycles %0d bad want 6 0", nr, nbad); end
      n_vec++; if (ins !== ref_word(32'h010)) begin n_err++; $display("FAIL blk1_word got %h want %h", ins, ref_word(32'h010)); end
      ref_install(32'h010);
      do_fetch(32'h000, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 0 || tmo) begin n_err++; $display("FAIL blk0_rehit got %0d want 0", nb); end
      n_vec++; if (ins !== ref_word(32'h000)) begin n_err++; $display("FAIL blk0_word got %h want %h", ins, ref_word(32'h000)); end
   endtask

   task automatic test_conflict();
      int nb, nr, nbad; logic [31:0] ins; bit tmo;
      do_fetch(32'h000, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 0 || tmo) begin n_err++; $display("FAIL conf_pre_hit got %0d want 0", nb); end
      do_fetch(32'h080, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 8 || tmo) begin n_err++; $display("FAIL conf_miss got %0d want 8", nb); end
      n_vec++; if (nr != 6 || nbad != 0) begin n_err++; $display("FAIL conf_addr got %0d cycles %0d bad want 6 0", nr, nbad); end
      n_vec++; if (ins !== ref_word(32'h080)) begin n_err++; $display("FAIL conf_word got %h want %h", ins, ref_word(32'h080)); end
      ref_install(32'h080);
      do_fetch(32'h000, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 8 || tmo) begin n_err++; $display("FAIL conf_evicted got %0d want 8", nb); end
      n_vec++; if (nr != 6 || nbad != 0) begin n_err++; $display("FAIL conf_refetch got %0d cycles %0d bad want 6 0", nr, nbad); end
      n_vec++; if (ins !== ref_word(32'h000)) begin n_err++; $display("FAIL conf_word0 got %h want %h", ins, ref_word(32'h000)); end
      ref_install(32'h000);
   endtask

   task automatic test_zero_latency();
      int nb, nr, nbad; logic [31:0] ins; bit tmo;
      mem_lat = 0;
      do_fetch(32'h028, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 3 || tmo) begin n_err++; $display("FAIL zlat_busy got %0d want 3", nb); end
      n_vec++; if (nr != 1 || nbad != 0) begin n_err++; $display("FAIL zlat_read got %0d cycles %0d bad want 1 0", nr, nbad); end
      n_vec++; if (ins !== ref_word(32'h028)) begin n_err++; $display("FAIL zlat_word got %h want %h", ins, ref_word(32'h028)); end
      ref_install(32'h028);
   endtask

   task automatic test_reset_mid_fetch();
      int nb, nr, nbad, rd; logic [31:0] ins; bit tmo, found, seen;
      mem_lat = 5;
      rd = 0; found = 1'b0;
      @(negedge clk);
      pc = 32'h030;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (mem_read === 1'b1) rd++;
         if (rd == 3) begin found = 1'b1; break; end
         @(negedge clk);
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL rst_fetch_reach got %0d reads want 3", rd); end
      reset = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_fetch_busy got %b want 0", busy); end
      @(posedge clk);
      #1;
      n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_fetch_mem_read got %b want 0", mem_read); end
      n_vec++; if (mem_addr !== 6'h00) begin n_err++; $display("FAIL rst_fetch_mem_addr got %h want 00", mem_addr); end
      reset = 1'b0;
      ref_clear();
      do_fetch(32'h030, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 8 || tmo) begin n_err++; $display("FAIL rst_refetch_busy got %0d want 8", nb); end
      n_vec++; if (ins !== ref_word(32'h030)) begin n_err++; $display("FAIL rst_refetch_word got %h want %h", ins, ref_word(32'h030)); end
      ref_install(32'h030);
      do_fetch(32'h000, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 8 || tmo) begin n_err++; $display("FAIL rst_cleared_valid got %0d want 8", nb); end
      ref_install(32'h000);
      // Reset while the block sits in UPDATE must not install it.
      mem_lat = 0; seen = 1'b0; found = 1'b0;
      @(negedge clk);
      pc = 32'h044;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mem_read === 1'b1) seen = 1'b1;
         else if (seen && busy === 1'b1) begin found = 1'b1; break; end
         @(negedge clk);
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL rst_upd_reach got none want update cycle"); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      ref_clear();
      do_fetch(32'h044, nb, nr, nbad, ins, tmo);
      n_vec++; if (nb != 3 || tmo) begin n_err++; $display("FAIL rst_upd_not_installed got %0d want 3", nb); end
      ref_install(32'h044);
   endtask

   task automatic test_random();
      int nb, nr, nbad, exp_nb, exp_nr; logic [31:0] ins, a, r; bit tmo, h;
      for (int k = 0; k < 200; k++) begin
         r = $urandom();
         a = {r[31:10], 2'b00, 1'($urandom_range(0, 1)), r[6:4], r[3:2], 2'b00};
         mem_lat = $urandom_range(0, 4);
         h = ref_hit(a);
         exp_nb = h ? 0 : mem_lat + 3;
         exp_nr = h ? 0 : mem_lat + 1;
         do_fetch(a, nb, nr, nbad, ins, tmo);
         n_vec++; if (nb != exp_nb || tmo) begin n_err++; $display("FAIL rnd_busy pc=%h got %0d want %0d", a, nb, exp_nb); end
         n_vec++; if (nr != exp_nr || nbad != 0) begin n_err++; $display("FAIL rnd_read pc=%h got %0d cycles %0d bad want %0d 0", a, nr, nbad, exp_nr); end
         n_vec++; if (ins !== ref_word(a)) begin n_err++; $display("FAIL rnd_word pc=%h got %h want %h", a, ins, ref_word(a)); end
         ref_install(a);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      mem_lat = 5;
      lat_cnt = 0;
      reset   = 1'b1;
      pc      = 32'h0;
      for (int i = 0; i < 64; i++) mem_blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_blk[0][31:0] = 32'h09000001;
      ref_clear();
      test_reset();
      test_cold_miss();
      test_same_block_hits();
      test_next_block();
      test_conflict();
      test_zero_latency();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
